seq_divider32x16: RTL
=====================

// Module: seq_divider32x16
//
// PURPOSE
//  Iterative radix-2 restoring divider. It is the inverse of the 16x16 multiplier used in the Convolution datapath.
//  - Inputs: 2*W-bit dividend, W-bit divisor.
//  - Outputs: W-bit quotient, W-bit remainder.
//  - Use: normalisation/rescaling of accumulated convolution products back to W-bit range.
//  - Throughput: one result per W+1 cycles; start/busy/done handshake.
//
// PARAMETERS
//  W   16   divisor/quotient/remainder width; dividend width is 2*W
//
// PORTS
//  clk          in   1    rising-edge clock
//  rst_n        in   1    synchronous active-low reset
//  start        in   1    request; sampled only when busy==0
//  a            in   2*W  dividend, captured on accepted start
//  b            in   W    divisor, captured on accepted start
//  busy         out  1    1 while an operation is in progress
//  done         out  1    one-cycle pulse: result outputs valid
//  quotient     out  W    floor(a/b); held until next accepted start
//  remainder    out  W    a - quotient*b; held until next accepted start
//  div_by_zero  out  1    b==0 on the last operation; held with result
//  overflow     out  1    a[2W-1:W] >= b, b!=0; held with result
//
// BEHAVIOUR
//  Reset (rst_n==0 at a clk edge):
//   - State goes to IDLE; all outputs 0.
//   - Any operation in flight is aborted and no done is produced.
//  States:
//   - IDLE: busy=0. An accepted start captures a/b and clears the flags; next state:
//     - DONE if b==0 or overflow (latency 1);
//     - RUN otherwise (count=W-1).
//   - RUN: busy=1, one quotient bit per cycle, W cycles; then DONE.
//   - DONE: busy=0, done=1 for exactly one cycle; then IDLE.
//     A start in DONE is accepted exactly as in IDLE (back-to-back).
//  Latency: start edge at cycle 0 -> done high in cycle W+1 (17 for W=16), normal case.
//  Datapath (restoring):
//   - r: W+1-bit partial remainder, init {1'b0, a[2W-1:W]}.
//   - Shift register: dividend low half.
//   - Each RUN cycle: t = {r[W-1:0], next dividend MSB}.
//     - t>=b: r=t-b, shift 1 into quotient.
//     - otherwise: r=t, shift 0 into quotient.
//   - Pre-check a[2W-1:W]<b guarantees t<2b, so r never exceeds W+1 bits.
//  Results at done:
//   - Normal: quotient=floor(a/b), remainder=r[W-1:0]; both flags 0.
//   - b==0: div_by_zero=1, overflow=0, quotient=all-ones, remainder=a[W-1:0].
//   - overflow: overflow=1, div_by_zero=0, quotient=all-ones, remainder=all-ones.
//  Holding and start rules:
//   - quotient/remainder/flags update only in the DONE-entry cycle; they are stable otherwise.
//   - start while busy==1 is ignored; the a/b changes are not captured.
//   - a/b may change freely after the accepting edge.
//   - Reset mid-RUN: outputs 0 on the next cycle; a new start after reset release behaves as from IDLE.
//  Invariant: for a non-error result, quotient*b + remainder == a and remainder < b.
//
// TESTING
//  1. a=32'h000493E0 (300000), b=16'h012C -> done at cycle 17, quotient=16'h03E8, remainder=0, flags 0.
//  2. a=32'hFFFE0001, b=16'hFFFF -> quotient=16'hFFFF, remainder=16'h0000, flags 0.
//  3. a=100, b=7 -> quotient=14, remainder=2; busy high for cycles 1..16 only.
//  4. a=32'h1234ABCD, b=0 -> done at cycle 1, div_by_zero=1, quotient=16'hFFFF, remainder=16'hABCD.
//  5. a=32'h00010000, b=1 -> done at cycle 1, overflow=1, quotient=remainder=16'hFFFF.
//  6. Stimulus: start pulsed with new a/b at cycle 5 of an op -> ignored, result matches first operands.
//     Start held high in the DONE cycle -> second op accepted, its done 17 cycles later.
//     rst_n low at cycle 8 -> busy=done=0 and outputs 0 next cycle, and no done follows.
//  Plus: randomised a with a[31:16]<b, checking the invariant over >=10000 ops.

Source files
------------

// File: rtl/seq_divider32x16_if.sv
// Start/busy/done handshake and result bus for the sequential divider.
// Master drives the request side; slave (the divider) drives busy, done and results.
interface seq_divider32x16_if #(
  parameter int W = 16
);
  logic             start;
  logic [2*W-1:0]   a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [W-1:0]     quotient;
  logic [W-1:0]     remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider32x16.sv
// Radix-2 restoring divider, 2W/W -> W quotient + W remainder; done W+1 cycles after start (1 on error).
// No backpressure: start is taken whenever busy==0 (IDLE or DONE) and ignored while running.
module seq_divider32x16 #(
  parameter int W = 16
) (
  input logic                clk,
  input logic                rst_n,
  seq_divider32x16_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [W:0]     r;
  logic [W-1:0]   sh;
  logic [W-1:0]   dv;
  logic [CW-1:0]  cnt;

  logic [W:0]     t;
  logic           ge;
  logic [W:0]     r_nxt;
  logic [W-1:0]   sh_nxt;
  logic           accept;
  logic           in_zero;
  logic           in_ovf;

  // sh holds the unconsumed dividend bits at the top and the quotient
  // bits shifted in at the bottom; after W steps it is the quotient.
  always_comb begin
    t      = {r[W-1:0], sh[W-1]};
    ge     = (t >= {1'b0, dv});
    r_nxt  = ge ? (t - {1'b0, dv}) : t;
    sh_nxt = {sh[W-2:0], ge};
  end

  assign accept  = bus.start && (state != RUN);
  assign in_zero = (bus.b == '0);
  assign in_ovf  = !in_zero && (bus.a[2*W-1:W] >= bus.b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      r               <= '0;
      sh              <= '0;
      dv              <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            dv              <= bus.b;
            sh              <= bus.a[W-1:0];
            r               <= {1'b0, bus.a[2*W-1:W]};
            cnt             <= CW'(W-1);
            bus.div_by_zero <= in_zero;
            bus.overflow    <= in_ovf;
            if (in_zero) begin
              state         <= DONE;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              bus.quotient  <= '1;
              bus.remainder <= bus.a[W-1:0];
            end else if (in_ovf) begin
              state         <= DONE;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              bus.quotient  <= '1;
              bus.remainder <= '1;
            end else begin
              state         <= RUN;
              bus.busy      <= 1'b1;
            end
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        RUN: begin
          r   <= r_nxt;
          sh  <= sh_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.quotient  <= sh_nxt;
            bus.remainder <= r_nxt[W-1:0];
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  // The overflow pre-check keeps every partial remainder below b, so the
  // extra bit of r is only headroom and must never be set while running.
  a_r_msb_clear: assert property (
    @(posedge clk) disable iff (!rst_n) (state == RUN) |-> !r[W]
  );

  a_done_not_busy: assert property (
    @(posedge clk) disable iff (!rst_n) bus.done |-> !bus.busy
  );

endmodule
